// File: rtl/store_sequencer_pkg.sv
// Shared store opcode encodings and lane helpers for the DMEM store path.
// The FNC_* values mirror the core's opcode definitions for the store funct3 field.
package store_sequencer_pkg;

   localparam logic [2:0] FNC_SB = 3'b000;
   localparam logic [2:0] FNC_SH = 3'b001;
   localparam logic [2:0] FNC_SW = 3'b010;

   // Unshifted byte mask for a store width; zero marks an illegal funct3.
   function automatic logic [3:0] fnc_base_mask(input logic [2:0] func3);
      case (func3)
         FNC_SB:  fnc_base_mask = 4'b0001;
         FNC_SH:  fnc_base_mask = 4'b0011;
         FNC_SW:  fnc_base_mask = 4'b1111;
         default: fnc_base_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/store_sequencer_if.sv
// Store request handshake plus DMEM write port and status outputs.
// A request transfers on a rising clk edge where req_valid && req_ready; req_* must stay stable while req_ready is 0.
interface store_sequencer_if #(
   parameter int MEM_AWIDTH = 14,
   parameter int CNT_WIDTH  = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_addr;
   logic [31:0]           req_data;
   logic [2:0]            req_func3;
   logic [MEM_AWIDTH-1:0] mem_addr;
   logic [31:0]           mem_din;
   logic [3:0]            mem_we;
   logic                  err;
   logic [CNT_WIDTH-1:0]  split_count;

   modport master (
      output req_valid, req_addr, req_data, req_func3,
      input  req_ready, mem_addr, mem_din, mem_we, err, split_count
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_func3,
      output req_ready, mem_addr, mem_din, mem_we, err, split_count
   );
endinterface

// File: rtl/store_sequencer_lane_gen.sv
// Combinational byte-lane generator: mask and lane-shifted data across a 64-bit window.
// Bytes outside the store width are zeroed before the shift so uncovered lanes read 0.
module store_lane_gen
   import store_sequencer_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  func3,
   input  logic [31:0] data,
   output logic [7:0]  m8,
   output logic [63:0] d64,
   output logic        split,
   output logic        illegal
);
   logic [3:0]  base;
   logic [31:0] data_m;

   assign base    = fnc_base_mask(func3);
   assign illegal = (base == 4'b0000);
   assign data_m  = data & {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};
   assign m8      = {4'b0000, base} << off;
   assign d64     = {32'b0, data_m} << {off, 3'b000};
   assign split   = (m8[7:4] != 4'b0000);
endmodule

// File: rtl/store_sequencer.sv
// Sequences stores onto the byte-masked DMEM port, splitting word-crossing stores in two beats.
// Holds the FSM, the beat-1 holding registers and the saturating split counter.
module store_sequencer
   import store_sequencer_pkg::*;
#(
   parameter int MEM_AWIDTH = 14,
   parameter int CNT_WIDTH  = 16
)(
   input  logic              clk,
   input  logic              rst,
   store_sequencer_if.slave  bus,
   output logic [1:0]        dbg_state_o
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      SPLIT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [MEM_AWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_din_q, mem_din_d;
   logic [3:0]            mem_we_q, mem_we_d;
   logic                  err_q, err_d;
   logic [MEM_AWIDTH-1:0] b1_addr_q, b1_addr_d;
   logic [31:0]           b1_din_q, b1_din_d;
   logic [3:0]            b1_we_q, b1_we_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic [7:0]            m8;
   logic [63:0]           d64;
   logic                  split;
   logic                  illegal;
   logic                  accept;
   logic                  pending;
   logic [MEM_AWIDTH-1:0] w0_addr;
   logic                  unused_addr_bits;

   store_lane_gen u_lane_gen (
      .off     (bus.req_addr[1:0]),
      .func3   (bus.req_func3),
      .data    (bus.req_data),
      .m8      (m8),
      .d64     (d64),
      .split   (split),
      .illegal (illegal)
   );

   assign unused_addr_bits = ^bus.req_addr[31:MEM_AWIDTH+2];
   assign w0_addr          = bus.req_addr[MEM_AWIDTH+1:2];
   assign pending          = (state_q == WRITE) && (b1_we_q != 4'b0000);
   assign bus.req_ready    = !pending;
   assign accept           = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d    = IDLE;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 4'b0000;
      err_d      = 1'b0;
      b1_addr_d  = b1_addr_q;
      b1_din_d   = b1_din_q;
      b1_we_d    = 4'b0000;
      cnt_d      = cnt_q;
      if (pending) begin
         state_d    = SPLIT;
         mem_addr_d = b1_addr_q;
         mem_din_d  = b1_din_q;
         mem_we_d   = b1_we_q;
      end else if (accept) begin
         err_d = illegal;
         if (!illegal) begin
            state_d    = WRITE;
            mem_addr_d = w0_addr;
            mem_din_d  = d64[31:0];
            mem_we_d   = m8[3:0];
            // Word address wraps naturally at 2^MEM_AWIDTH.
            b1_addr_d  = w0_addr + {{(MEM_AWIDTH-1){1'b0}}, 1'b1};
            b1_din_d   = d64[63:32];
            b1_we_d    = m8[7:4];
            if (split && (cnt_q != {CNT_WIDTH{1'b1}})) begin
               cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= '0;
         err_q      <= 1'b0;
         b1_addr_q  <= '0;
         b1_din_q   <= '0;
         b1_we_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         err_q      <= err_d;
         b1_addr_q  <= b1_addr_d;
         b1_din_q   <= b1_din_d;
         b1_we_q    <= b1_we_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_din     = mem_din_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.err         = err_q;
   assign bus.split_count = cnt_q;
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: expected write beats are queued by the driver
// and popped by a negedge monitor whenever mem_we is nonzero.
module tb_store_sequencer;
   localparam int AW = 14;
   localparam int CW = 16;
   localparam int EW = AW + 4 + 32;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [EW-1:0] exp_q[$];
   int            wr_cyc[$];

   store_sequencer_if #(.MEM_AWIDTH(AW), .CNT_WIDTH(CW)) sif ();

   store_sequencer #(.MEM_AWIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (sif.slave),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic push_beat(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
      exp_q.push_back({a, we, d});
   endtask

   // driver: present a request, hold it until accepted, return #1 after the accepting edge
   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      int w;
      w = 0;
      sif.req_valid = 1'b1;
      sif.req_addr  = a;
      sif.req_data  = d;
      sif.req_func3 = f;
      #0;
      while (!sif.req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 required=1");
      end
      @(posedge clk);
      #1;
      sif.req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [EW-1:0] got;
      logic [EW-1:0] e;
      cyc++;
      if (sif.mem_we != 4'b0000) begin
         wr_cyc.push_back(cyc);
         got = {sif.mem_addr, sif.mem_we, sif.mem_din};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual=0x%0h required=no_write", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL write_beat actual addr=0x%0h we=%b din=0x%0h required addr=0x%0h we=%b din=0x%0h",
                        got[EW-1:36], got[35:32], got[31:0], e[EW-1:36], e[35:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      int n0;
      rst           = 1'b1;
      sif.req_valid = 1'b0;
      sif.req_addr  = '0;
      sif.req_data  = '0;
      sif.req_func3 = 3'b000;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {63'b0, sif.req_ready}, 64'd1);
      chk("rst_we", {60'b0, sif.mem_we}, 64'd0);
      chk("rst_addr", {50'b0, sif.mem_addr}, 64'd0);
      chk("rst_din", {32'b0, sif.mem_din}, 64'd0);
      chk("rst_err", {63'b0, sif.err}, 64'd0);
      chk("rst_cnt", {48'b0, sif.split_count}, 64'd0);
      chk("rst_state", {62'b0, dbg_state}, 64'd0);

      // aligned SW
      push_beat(14'd4, 4'b1111, 32'hDEADBEEF);
      send(32'h0000_0010, 32'hDEADBEEF, 3'b010);
      chk("sw_ready", {63'b0, sif.req_ready}, 64'd1);
      chk("sw_state", {62'b0, dbg_state}, 64'd1);

      // SB to top lane
      push_beat(14'd4, 4'b1000, 32'hA500_0000);
      send(32'h0000_0013, 32'h0000_00A5, 3'b000);

      // SH crossing a word boundary
      push_beat(14'd2, 4'b1000, 32'hEF00_0000);
      push_beat(14'd3, 4'b0001, 32'h0000_00BE);
      send(32'h0000_000B, 32'h0000_BEEF, 3'b001);
      chk("sh_ready_low", {63'b0, sif.req_ready}, 64'd0);
      chk("sh_cnt", {48'b0, sif.split_count}, 64'd1);
      idle(1);
      chk("sh_state_split", {62'b0, dbg_state}, 64'd2);

      // SW at top word wrapping to word 0
      push_beat({AW{1'b1}}, 4'b1100, 32'h3344_0000);
      push_beat(14'd0, 4'b0011, 32'h0000_1122);
      send(4 * ((1 << AW) - 1) + 2, 32'h1122_3344, 3'b010);
      chk("wrap_cnt", {48'b0, sif.split_count}, 64'd2);
      idle(3);
      chk("idle_we", {60'b0, sif.mem_we}, 64'd0);
      chk("idle_addr_hold", {50'b0, sif.mem_addr}, 64'd0);
      chk("idle_din_hold", {32'b0, sif.mem_din}, 64'h1122);
      chk("idle_state", {62'b0, dbg_state}, 64'd0);

      // four back-to-back SB, no bubbles
      n0 = wr_cyc.size();
      push_beat(14'd0, 4'b0001, 32'h0000_0011);
      push_beat(14'd0, 4'b0010, 32'h0000_2200);
      push_beat(14'd0, 4'b0100, 32'h0033_0000);
      push_beat(14'd0, 4'b1000, 32'h4400_0000);
      send(32'h0, 32'h11, 3'b000);
      send(32'h1, 32'h22, 3'b000);
      send(32'h2, 32'h33, 3'b000);
      send(32'h3, 32'h44, 3'b000);
      idle(2);
      chk("b2b_writes", 64'(wr_cyc.size() - n0), 64'd4);
      if (wr_cyc.size() >= n0 + 4)
         chk("b2b_span", 64'(wr_cyc[n0+3] - wr_cyc[n0]), 64'd3);

      // uncovered lanes are zero even with dirty upper data bits
      push_beat(14'd5, 4'b0010, 32'h0000_FF00);
      send(32'h0000_0015, 32'hFFFF_FFFF, 3'b000);
      idle(1);

      // illegal funct3
      send(32'h0000_0040, 32'h1234_5678, 3'b011);
      chk("ill_err", {63'b0, sif.err}, 64'd1);
      chk("ill_we", {60'b0, sif.mem_we}, 64'd0);
      chk("ill_state", {62'b0, dbg_state}, 64'd0);
      chk("ill_cnt", {48'b0, sif.split_count}, 64'd2);
      idle(1);
      chk("ill_err_pulse", {63'b0, sif.err}, 64'd0);

      // reset with beat 1 pending: only beat 0 ever appears
      push_beat(14'd8, 4'b1110, 32'hFEBA_BE00);
      send(32'h0000_0021, 32'hCAFE_BABE, 3'b010);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rsplit_we", {60'b0, sif.mem_we}, 64'd0);
      chk("rsplit_addr", {50'b0, sif.mem_addr}, 64'd0);
      chk("rsplit_din", {32'b0, sif.mem_din}, 64'd0);
      chk("rsplit_cnt", {48'b0, sif.split_count}, 64'd0);
      chk("rsplit_state", {62'b0, dbg_state}, 64'd0);
      rst = 1'b0;
      idle(3);
      chk("rsplit_ready", {63'b0, sif.req_ready}, 64'd1);
      chk("rsplit_we_after", {60'b0, sif.mem_we}, 64'd0);

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
